// File: rtl/sample_multi.sv
// sample_multi: NCH-channel sample-and-hold for valid/ready streams.
// Each channel keeps its last valid sample and re-offers it downstream until a
// newer one is captured. An optional staleness timeout invalidates old samples.
// Build option: define SAMPLE_DROP_CNT_EN to add the per-channel drop_cnt port
// counting input beats discarded while an offer is pending.
module sample_multi #(
    parameter int unsigned    DIN        = 8,
    parameter int unsigned    NCH        = 2,
    parameter int unsigned    HOLD       = 1,
    parameter int unsigned    LATENCY    = 0,
    parameter logic [DIN-1:0] INIT       = '0,
    parameter int unsigned    INIT_VALID = 0,
    parameter int unsigned    STALE      = 0,
    parameter int unsigned    CNT_W      = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH-1:0]       din_valid,
    output logic [NCH-1:0]       din_ready,
    input  logic [NCH*DIN-1:0]   din_data,
    output logic [NCH-1:0]       dout_valid,
    input  logic [NCH-1:0]       dout_ready,
    output logic [NCH*DIN-1:0]   dout_data
`ifdef SAMPLE_DROP_CNT_EN
    ,
    output logic [NCH*CNT_W-1:0] drop_cnt
`endif
);

    localparam logic HOLD_ON   = (HOLD != 0);
    localparam logic BYPASS_ON = (LATENCY == 0);
    localparam logic INIT_ON   = (INIT_VALID != 0);

    if (DIN < 1 || NCH < 1 || CNT_W < 1) begin : g_bad_param
        $error("sample_multi: DIN, NCH and CNT_W must be >= 1");
    end

    // Inputs are never back-pressured.
    assign din_ready = '1;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [DIN-1:0] din_i;
        logic           dv_i;
        logic           rdy_i;
        logic [DIN-1:0] reg_data;
        logic           reg_valid;
        logic           consuming;
        logic           bypass;
        logic           out_valid;
        logic [DIN-1:0] out_data;
        logic           handshake;
        logic           slot;
        logic           capture;
        logic           expire;

        assign din_i = din_data[i*DIN +: DIN];
        assign dv_i  = din_valid[i];
        assign rdy_i = dout_ready[i];

        // Output selection, handshake and capture-slot decode for this channel.
        always_comb begin
            bypass    = BYPASS_ON && !consuming && (dv_i || !HOLD_ON);
            out_valid = bypass ? dv_i  : reg_valid;
            out_data  = bypass ? din_i : reg_data;
            handshake = out_valid && rdy_i;
            slot      = handshake || !consuming;
            capture   = slot && (dv_i || !HOLD_ON);
        end

        assign dout_valid[i]            = out_valid;
        assign dout_data[i*DIN +: DIN]  = out_data;

        // Sample register and offer tracking; once offered, the output is
        // served from the register until it is accepted.
        always_ff @(posedge clk) begin
            if (rst) begin
                reg_valid <= INIT_ON;
                reg_data  <= INIT_ON ? INIT : '0;
                consuming <= 1'b0;
            end else begin
                consuming <= out_valid && !handshake;
                if (capture) begin
                    reg_valid <= dv_i;
                    reg_data  <= din_i;
                end else if (expire) begin
                    reg_valid <= 1'b0;
                end
            end
        end

        if (STALE > 0 && HOLD_ON) begin : g_stale
            localparam int unsigned AGE_W = $clog2(STALE + 1);
            logic [AGE_W-1:0] age;

            // Expiry waits for any pending offer to be accepted; a capture wins.
            assign expire = reg_valid && (age == AGE_W'(STALE)) && slot && !capture;

            // Age of the held sample, saturating at STALE.
            always_ff @(posedge clk) begin
                if (rst) begin
                    age <= '0;
                end else if (capture) begin
                    age <= '0;
                end else if (reg_valid && age != AGE_W'(STALE)) begin
                    age <= age + AGE_W'(1);
                end
            end
        end else begin : g_no_stale
            assign expire = 1'b0;
        end

`ifdef SAMPLE_DROP_CNT_EN
        logic             drop;
        logic [CNT_W-1:0] cnt;

        assign drop = dv_i && consuming && !handshake;

        // Saturating count of beats discarded while an offer was pending.
        always_ff @(posedge clk) begin
            if (rst) begin
                cnt <= '0;
            end else if (drop && cnt != '1) begin
                cnt <= cnt + CNT_W'(1);
            end
        end

        assign drop_cnt[i*CNT_W +: CNT_W] = cnt;
`endif
    end

endmodule
